xfer_seq: RTL

XFER_SEQ -- requirements
Module: xfer_seq

---
 rtl/xfer_seq_pkg.sv | 24 ++
 rtl/xfer_seq.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/xfer_seq_pkg.sv
// rtl/xfer_seq_pkg.sv - shared width default and state encoding for the block-move sequencer
//
// Purpose: single home for the datapath width default and the sequencer
// state type, imported by xfer_seq and by anything that needs to decode
// its state.
package xfer_seq_pkg;

  // Default width of pointers, word count and data words.
  localparam int XFER_WIDTH = 16;

  // IDLE  : waiting for start
  // RD    : reading the word at the source pointer
  // WR    : writing the buffered word to the destination pointer
  // STEP  : one-cycle pointer advance and count decrement
  // DONE  : one-cycle completion pulse
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_WR   = 3'd2,
    ST_STEP = 3'd3,
    ST_DONE = 3'd4
  } xfer_state_t;

endpackage

// File: rtl/xfer_seq.sv
// rtl/xfer_seq.sv - block-move sequencer copying words from pointer A to pointer B
//
// Purpose: on an accepted start, moves i_count words one at a time. Each word
// is read at i_a_val, buffered, written at i_b_val, then both pointers are
// stepped (up or down per the latched direction) through strobes to the
// external A/B pointer registers. i_abort cancels a move in progress.
//
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_start, i_count, i_dir   move request, word count, 0=ascending 1=descending
//   i_abort                   cancel an in-progress move
//   i_a_val, i_b_val          current source / destination pointers
//   o_a_inc/o_a_dec           source pointer step strobes
//   o_b_inc/o_b_dec           destination pointer step strobes
//   o_mem_addr                memory address (0 outside RD/WR)
//   o_mem_rd, o_mem_wr        memory request strobes, held until i_mem_ready
//   o_mem_wdata, i_mem_rdata  write data (0 outside WR) / read data
//   i_mem_ready               memory completes the current request this cycle
//   o_busy                    high in RD, WR, STEP
//   o_done                    one-cycle completion pulse
module xfer_seq
  import xfer_seq_pkg::*;
#(
  parameter int WIDTH = XFER_WIDTH
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_dir,
  input  logic             i_abort,
  input  logic [WIDTH-1:0] i_a_val,
  input  logic [WIDTH-1:0] i_b_val,
  output logic             o_a_inc,
  output logic             o_a_dec,
  output logic             o_b_inc,
  output logic             o_b_dec,
  output logic [WIDTH-1:0] o_mem_addr,
  output logic             o_mem_rd,
  output logic             o_mem_wr,
  output logic [WIDTH-1:0] o_mem_wdata,
  input  logic [WIDTH-1:0] i_mem_rdata,
  input  logic             i_mem_ready,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  xfer_state_t      r_state;
  xfer_state_t      w_next_state;
  logic [WIDTH-1:0] r_remaining;
  logic [WIDTH-1:0] r_buffer;
  logic             r_dir;

  logic w_load;
  logic w_capture;
  logic w_step;

  // A zero-length request is accepted but never loads the counter; it goes
  // straight to DONE.
  assign w_load    = (r_state == ST_IDLE) && i_start && (i_count != '0);
  assign w_capture = (r_state == ST_RD) && i_mem_ready && !i_abort;
  assign w_step    = (r_state == ST_STEP) && !i_abort;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_buffer    <= '0;
      r_dir       <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_remaining <= i_count;
        r_dir       <= i_dir;
      end else if (w_step) begin
        r_remaining <= r_remaining - ONE;
      end
      if (w_capture) begin
        r_buffer <= i_mem_rdata;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    o_a_inc      = 1'b0;
    o_a_dec      = 1'b0;
    o_b_inc      = 1'b0;
    o_b_dec      = 1'b0;
    o_mem_addr   = '0;
    o_mem_rd     = 1'b0;
    o_mem_wr     = 1'b0;
    o_mem_wdata  = '0;
    o_busy       = 1'b0;
    o_done       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_next_state = (i_count != '0) ? ST_RD : ST_DONE;
        end
      end

      ST_RD: begin
        o_busy     = 1'b1;
        o_mem_rd   = 1'b1;
        o_mem_addr = i_a_val;
        if (i_abort) begin
          w_next_state = ST_IDLE;
        end else if (i_mem_ready) begin
          w_next_state = ST_WR;
        end
      end

      ST_WR: begin
        o_busy      = 1'b1;
        o_mem_wr    = 1'b1;
        o_mem_addr  = i_b_val;
        o_mem_wdata = r_buffer;
        if (i_abort) begin
          w_next_state = ST_IDLE;
        end else if (i_mem_ready) begin
          w_next_state = ST_STEP;
        end
      end

      ST_STEP: begin
        o_busy = 1'b1;
        if (i_abort) begin
          // A cancelled step must leave the pointers where they are.
          w_next_state = ST_IDLE;
        end else begin
          o_a_inc = !r_dir;
          o_b_inc = !r_dir;
          o_a_dec = r_dir;
          o_b_dec = r_dir;
          // The count is compared before its decrement lands, so 1 means
          // this step finishes the final word.
          w_next_state = (r_remaining == ONE) ? ST_DONE : ST_RD;
        end
      end

      ST_DONE: begin
        o_done       = 1'b1;
        w_next_state = ST_IDLE;
      end

      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

endmodule
